// File: rtl/fb_access_arbiter.sv
// Framebuffer port arbiter: display reader with fixed priority, bounded writer
// starvation, round-robin between two pixel writers, out-of-range filtering.
module fb_access_arbiter #(
    parameter int DISPLAY_WIDTH  = 128,
    parameter int DISPLAY_HEIGHT = 64,
    parameter int READ_LATENCY   = 1,
    parameter int STARVE_LIMIT   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_req,
    input  logic [7:0] rd_xpos,
    input  logic [7:0] rd_ypos,
    input  logic       rd_mode,
    output logic       rd_ack,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       wr0_req,
    input  logic [7:0] wr0_xpos,
    input  logic [7:0] wr0_ypos,
    input  logic       wr0_pix,
    output logic       wr0_ack,
    input  logic       wr1_req,
    input  logic [7:0] wr1_xpos,
    input  logic [7:0] wr1_ypos,
    input  logic       wr1_pix,
    output logic       wr1_ack,
    output logic       fb_re,
    output logic       fb_we,
    output logic [7:0] fb_xpos,
    output logic [7:0] fb_ypos,
    output logic       fb_mode,
    output logic       fb_din,
    input  logic [7:0] fb_dout,
    output logic       busy,
    output logic [1:0] grant_owner
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE
    } state_t;

    localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SCW-1:0] S_MAX  = SCW'(STARVE_LIMIT);
    localparam logic [8:0]     X_LIM  = 9'(DISPLAY_WIDTH);
    localparam logic [8:0]     Y_LIM  = 9'(DISPLAY_HEIGHT);
    localparam logic [2:0]     W_LAST = 3'(READ_LATENCY - 1);

    state_t         state;
    logic [SCW-1:0] starve_cnt;
    logic           last_wr;
    logic           rd_oor;
    logic [2:0]     wait_cnt;

    logic       wr_any;
    logic       starved;
    logic       pick1;
    logic [7:0] wx;
    logic [7:0] wy;
    logic       wpix;
    logic       rd_ok;
    logic       wr_ok;

    function automatic logic in_range(input logic [7:0] x, input logic [7:0] y);
        return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    endfunction

    // the writer opposite last_wr wins when pending, otherwise last_wr
    assign wr_any  = wr0_req | wr1_req;
    assign starved = wr_any && (starve_cnt == S_MAX);
    assign pick1   = last_wr ? !wr0_req : wr1_req;
    assign wx      = pick1 ? wr1_xpos : wr0_xpos;
    assign wy      = pick1 ? wr1_ypos : wr0_ypos;
    assign wpix    = pick1 ? wr1_pix : wr0_pix;
    assign rd_ok   = in_range(rd_xpos, rd_ypos);
    assign wr_ok   = in_range(wx, wy);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            last_wr     <= 1'b1;
            rd_oor      <= 1'b0;
            wait_cnt    <= '0;
            rd_ack      <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= 8'h00;
            wr0_ack     <= 1'b0;
            wr1_ack     <= 1'b0;
            fb_re       <= 1'b0;
            fb_we       <= 1'b0;
            fb_xpos     <= 8'h00;
            fb_ypos     <= 8'h00;
            fb_mode     <= 1'b0;
            fb_din      <= 1'b0;
            busy        <= 1'b0;
            grant_owner <= 2'd0;
        end else begin
            rd_ack   <= 1'b0;
            rd_valid <= 1'b0;
            wr0_ack  <= 1'b0;
            wr1_ack  <= 1'b0;
            fb_re    <= 1'b0;
            fb_we    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wr_any && (starved || !rd_req)) begin
                        state       <= WR_ISSUE;
                        busy        <= 1'b1;
                        grant_owner <= pick1 ? 2'd3 : 2'd2;
                        wr0_ack     <= !pick1;
                        wr1_ack     <= pick1;
                        last_wr     <= pick1;
                        starve_cnt  <= '0;
                        fb_xpos     <= wx;
                        fb_ypos     <= wy;
                        fb_din      <= wpix;
                        fb_we       <= wr_ok;
                    end else if (rd_req) begin
                        state       <= RD_ISSUE;
                        busy        <= 1'b1;
                        grant_owner <= 2'd1;
                        rd_ack      <= 1'b1;
                        fb_xpos     <= rd_xpos;
                        fb_ypos     <= rd_ypos;
                        fb_mode     <= rd_mode;
                        fb_re       <= rd_ok;
                        rd_oor      <= !rd_ok;
                        if (!wr_any)
                            starve_cnt <= '0;
                        else if (starve_cnt != S_MAX)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                RD_ISSUE: begin
                    state    <= RD_WAIT;
                    wait_cnt <= '0;
                end
                RD_WAIT: begin
                    if (wait_cnt == W_LAST) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        grant_owner <= 2'd0;
                        rd_valid    <= 1'b1;
                        rd_data     <= rd_oor ? 8'h00 : fb_dout;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WR_ISSUE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    grant_owner <= 2'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: directed scenarios plus random traffic against
// a cycle-count transaction model of the arbitration rules.
module tb_fb_access_arbiter;

    localparam int W   = 128;
    localparam int H   = 64;
    localparam int LAT = 1;
    localparam int SL  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rd_req, rd_mode;
    logic [7:0] rd_xpos, rd_ypos;
    logic       wr0_req, wr0_pix, wr1_req, wr1_pix;
    logic [7:0] wr0_xpos, wr0_ypos, wr1_xpos, wr1_ypos;

    logic       rd_ack, rd_valid, wr0_ack, wr1_ack, fb_re, fb_we, fb_mode, fb_din, busy;
    logic [7:0] rd_data, fb_xpos, fb_ypos, fb_dout;
    logic [1:0] grant_owner;

    logic       u3_rd_ack, u3_rd_valid, u3_wr0_ack, u3_wr1_ack, u3_fb_re, u3_fb_we;
    logic       u3_fb_mode, u3_fb_din, u3_busy;
    logic [7:0] u3_rd_data, u3_fb_xpos, u3_fb_ypos, u3_fb_dout;
    logic [1:0] u3_grant_owner;

    fb_access_arbiter #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .READ_LATENCY(LAT),
                        .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_xpos(rd_xpos), .rd_ypos(rd_ypos), .rd_mode(rd_mode),
        .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr0_req(wr0_req), .wr0_xpos(wr0_xpos), .wr0_ypos(wr0_ypos), .wr0_pix(wr0_pix),
        .wr0_ack(wr0_ack),
        .wr1_req(wr1_req), .wr1_xpos(wr1_xpos), .wr1_ypos(wr1_ypos), .wr1_pix(wr1_pix),
        .wr1_ack(wr1_ack),
        .fb_re(fb_re), .fb_we(fb_we), .fb_xpos(fb_xpos), .fb_ypos(fb_ypos),
        .fb_mode(fb_mode), .fb_din(fb_din), .fb_dout(fb_dout),
        .busy(busy), .grant_owner(grant_owner)
    );

    fb_access_arbiter #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .READ_LATENCY(3),
                        .STARVE_LIMIT(SL)) u3 (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_xpos(rd_xpos), .rd_ypos(rd_ypos), .rd_mode(rd_mode),
        .rd_ack(u3_rd_ack), .rd_valid(u3_rd_valid), .rd_data(u3_rd_data),
        .wr0_req(wr0_req), .wr0_xpos(wr0_xpos), .wr0_ypos(wr0_ypos), .wr0_pix(wr0_pix),
        .wr0_ack(u3_wr0_ack),
        .wr1_req(wr1_req), .wr1_xpos(wr1_xpos), .wr1_ypos(wr1_ypos), .wr1_pix(wr1_pix),
        .wr1_ack(u3_wr1_ack),
        .fb_re(u3_fb_re), .fb_we(u3_fb_we), .fb_xpos(u3_fb_xpos), .fb_ypos(u3_fb_ypos),
        .fb_mode(u3_fb_mode), .fb_din(u3_fb_din), .fb_dout(u3_fb_dout),
        .busy(u3_busy), .grant_owner(u3_grant_owner)
    );

    function automatic logic [7:0] mem_val(input logic [7:0] x, input logic [7:0] y,
                                           input logic m);
        return {x[3:0], y[3:0]} ^ {m, 7'b0} ^ 8'h75;
    endfunction

    // framebuffer models: data appears READ_LATENCY cycles after fb_re is sampled
    logic [7:0] pipe1;
    logic [7:0] pipe3 [0:2];
    always @(posedge clk) begin
        pipe1    <= fb_re ? mem_val(fb_xpos, fb_ypos, fb_mode) : 8'h3C;
        pipe3[0] <= u3_fb_re ? mem_val(u3_fb_xpos, u3_fb_ypos, u3_fb_mode) : 8'h3C;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign fb_dout    = pipe1;
    assign u3_fb_dout = pipe3[2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model state (cycle numbers of the next IDLE and of rd_valid)
    int       cyc = 0;
    int       m_idle = 0;
    int       m_vcyc = -1;
    int       m_starve = 0;
    bit       m_last = 1'b1;
    int       m_owner = 0;
    logic [7:0] m_vdata = 8'h00;

    logic       e_rd_ack, e_rd_valid, e_wr0, e_wr1, e_re, e_we, e_mode, e_din, e_busy;
    logic [7:0] e_rd_data, e_x, e_y;
    logic [1:0] e_owner;

    logic       p_rst, p_rd, p_rm, p_w0, p_w1, p_p0, p_p1;
    logic [7:0] p_rx, p_ry, p_x0, p_y0, p_x1, p_y1;

    function automatic bit in_rng(input logic [7:0] x, input logic [7:0] y);
        return (int'(x) < W) && (int'(y) < H);
    endfunction

    task automatic model_step();
        int c, n;
        bit other, wsel, ok;
        c = cyc;
        n = cyc + 1;
        {e_rd_ack, e_rd_valid, e_wr0, e_wr1, e_re, e_we} = '0;
        if (!p_rst) begin
            m_idle = n; m_vcyc = -1; m_starve = 0; m_last = 1'b1; m_owner = 0;
            e_rd_data = 8'h00; e_x = 8'h00; e_y = 8'h00; e_mode = 1'b0; e_din = 1'b0;
        end else if (c == m_idle) begin
            other = !m_last;
            wsel  = (other ? p_w1 : p_w0) ? other : m_last;
            if ((p_w0 || p_w1) && (m_starve == SL || !p_rd)) begin
                if (wsel) e_wr1 = 1'b1; else e_wr0 = 1'b1;
                e_x   = wsel ? p_x1 : p_x0;
                e_y   = wsel ? p_y1 : p_y0;
                e_din = wsel ? p_p1 : p_p0;
                e_we  = in_rng(e_x, e_y);
                m_owner = wsel ? 3 : 2;
                m_last = wsel;
                m_starve = 0;
                m_idle = c + 2;
            end else if (p_rd) begin
                e_rd_ack = 1'b1;
                e_x = p_rx; e_y = p_ry; e_mode = p_rm;
                ok = in_rng(p_rx, p_ry);
                e_re = ok;
                m_owner = 1;
                m_idle = c + 2 + LAT;
                m_vcyc = c + 2 + LAT;
                m_vdata = ok ? mem_val(p_rx, p_ry, p_rm) : 8'h00;
                if (p_w0 || p_w1) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
                else m_starve = 0;
            end else begin
                m_starve = 0;
                m_idle = n;
            end
        end
        if (n == m_vcyc) begin
            e_rd_valid = 1'b1;
            e_rd_data = m_vdata;
        end
        e_busy  = (n < m_idle);
        e_owner = e_busy ? 2'(m_owner) : 2'd0;
    endtask

    task automatic tick();
        p_rst = reset; p_rd = rd_req; p_rx = rd_xpos; p_ry = rd_ypos; p_rm = rd_mode;
        p_w0 = wr0_req; p_x0 = wr0_xpos; p_y0 = wr0_ypos; p_p0 = wr0_pix;
        p_w1 = wr1_req; p_x1 = wr1_xpos; p_y1 = wr1_ypos; p_p1 = wr1_pix;
        @(posedge clk);
        #1;
        model_step();
        cyc++;
        chk("outputs_vs_model",
            {rd_ack, rd_valid, rd_data, wr0_ack, wr1_ack, fb_re, fb_we,
             fb_xpos, fb_ypos, fb_mode, fb_din, busy, grant_owner},
            {e_rd_ack, e_rd_valid, e_rd_data, e_wr0, e_wr1, e_re, e_we,
             e_x, e_y, e_mode, e_din, e_busy, e_owner});
        chk("re_we_exclusive", fb_re & fb_we, 1'b0);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return rd_ack;
            1: return wr0_ack;
            default: return wr1_ack;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (sig(sel) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk("wait_timeout", at >= 0, 1'b1);
    endtask

    initial begin
        int t, cnt;
        reset = 1'b0;
        rd_req = 0; rd_xpos = 0; rd_ypos = 0; rd_mode = 0;
        wr0_req = 0; wr0_xpos = 0; wr0_ypos = 0; wr0_pix = 0;
        wr1_req = 0; wr1_xpos = 0; wr1_ypos = 0; wr1_pix = 0;
        repeat (3) tick();
        chk("reset_outputs",
            {rd_ack, rd_valid, rd_data, wr0_ack, wr1_ack, fb_re, fb_we,
             fb_xpos, fb_ypos, fb_mode, fb_din, busy, grant_owner}, '0);
        reset = 1'b1;
        tick();

        // basic read, latency 1 and latency 3
        rd_xpos = 5; rd_ypos = 16; rd_mode = 1; rd_req = 1;
        wait_sig(0, 10, t);
        chk("u3_rd_ack_same_cycle", u3_rd_ack, 1'b1);
        chk("read_fb_bus", {fb_re, fb_xpos, fb_ypos, fb_mode}, {1'b1, 8'd5, 8'd16, 1'b1});
        rd_req = 0;
        tick();
        chk("rd_valid_early", rd_valid, 1'b0);
        tick();
        chk("rd_valid_t1p2", {rd_valid, rd_data}, {1'b1, 8'hA5});
        chk("u3_valid_early", u3_rd_valid, 1'b0);
        tick();
        chk("u3_valid_t1p3", u3_rd_valid, 1'b0);
        tick();
        chk("u3_valid_t1p4", {u3_rd_valid, u3_rd_data}, {1'b1, 8'hA5});
        repeat (3) tick();

        // simultaneous writers
        wr0_xpos = 10; wr0_ypos = 20; wr0_pix = 1; wr0_req = 1;
        wr1_xpos = 11; wr1_ypos = 20; wr1_pix = 0; wr1_req = 1;
        wait_sig(1, 10, t);
        chk("wr0_first", {wr1_ack, fb_we, fb_xpos, fb_ypos, fb_din},
            {1'b0, 1'b1, 8'd10, 8'd20, 1'b1});
        wr0_req = 0;
        tick();
        tick();
        chk("wr1_second", {wr1_ack, fb_we, fb_xpos, fb_ypos, fb_din},
            {1'b1, 1'b1, 8'd11, 8'd20, 1'b0});
        wr1_req = 0;
        repeat (2) tick();

        // starvation bound, twice
        rd_xpos = 7; rd_ypos = 3; rd_mode = 0; rd_req = 1;
        wr0_xpos = 20; wr0_ypos = 30; wr0_pix = 1; wr0_req = 1;
        for (int round = 0; round < 2; round++) begin
            cnt = 0;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (rd_ack) cnt++;
                if (wr0_ack) break;
            end
            wr0_req = 0;
            chk("starve_reads", cnt, SL);
            repeat (10) tick();
            wr0_req = round == 0;
        end
        rd_req = 0;
        repeat (6) tick();

        // reset in RD_WAIT
        rd_xpos = 9; rd_ypos = 9; rd_mode = 1; rd_req = 1;
        wait_sig(0, 10, t);
        rd_req = 0;
        tick();
        reset = 1'b0;
        tick();
        chk("reset_midread",
            {rd_ack, rd_valid, rd_data, wr0_ack, wr1_ack, fb_re, fb_we,
             fb_xpos, fb_ypos, fb_mode, fb_din, busy, grant_owner}, '0);
        reset = 1'b1;
        tick();
        chk("no_valid_after_reset", {rd_valid, rd_data}, 9'h000);
        wr0_xpos = 30; wr0_ypos = 1; wr0_pix = 1; wr0_req = 1;
        wr1_xpos = 31; wr1_ypos = 1; wr1_pix = 0; wr1_req = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr0_ack || wr1_ack) break;
        end
        chk("rr_after_reset", {wr0_ack, wr1_ack}, 2'b10);
        wr0_req = 0;
        wait_sig(2, 10, t);
        wr1_req = 0;
        repeat (2) tick();

        // out-of-range filtering
        wr0_xpos = 128; wr0_ypos = 0; wr0_pix = 1; wr0_req = 1;
        wait_sig(1, 10, t);
        chk("oor_write_dropped", fb_we, 1'b0);
        wr0_req = 0;
        rd_xpos = 0; rd_ypos = 64; rd_mode = 0; rd_req = 1;
        wait_sig(0, 10, t);
        chk("oor_read_no_re", fb_re, 1'b0);
        rd_req = 0;
        tick();
        tick();
        chk("oor_read_data", {rd_valid, rd_data}, {1'b1, 8'h00});
        repeat (2) tick();

        // idle stretch
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_quiet", {busy, grant_owner, fb_re, fb_we}, 5'b0);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(0, 499) != 0);
            if (rd_ack) rd_req = 0;
            else if (!rd_req && $urandom_range(0, 3) == 0) begin
                rd_req = 1; rd_mode = 1'($urandom_range(0, 1));
                rd_xpos = 8'($urandom_range(0, 135)); rd_ypos = 8'($urandom_range(0, 70));
            end
            if (wr0_ack) wr0_req = 0;
            else if (!wr0_req && $urandom_range(0, 2) == 0) begin
                wr0_req = 1; wr0_pix = 1'($urandom_range(0, 1));
                wr0_xpos = 8'($urandom_range(0, 135)); wr0_ypos = 8'($urandom_range(0, 70));
            end
            if (wr1_ack) wr1_req = 0;
            else if (!wr1_req && $urandom_range(0, 2) == 0) begin
                wr1_req = 1; wr1_pix = 1'($urandom_range(0, 1));
                wr1_xpos = 8'($urandom_range(0, 135)); wr1_ypos = 8'($urandom_range(0, 70));
            end
        end
        reset = 1'b1;
        rd_req = 0; wr0_req = 0; wr1_req = 0;
        repeat (10) tick();
        chk("u3_drained",
            {u3_busy, u3_grant_owner, u3_rd_ack, u3_rd_valid, u3_wr0_ack, u3_wr1_ack,
             u3_fb_re, u3_fb_we}, 9'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
